dma_att_scheduler: RTL

Schedules external DMA traffic into the openMSP430 DMA port under the attestation security rules. Incoming requests are queued in a small buffer and issued to memory one at a time. Issue is held while the CPU executes attestation code in secure ROM. Any request aimed at the secure key/stack region or the attestation counter is refused and locks the port until the CPU passes through the reset handler. The block sits between the DMA master and the core's DMA interface, beside the existing DMA/stack reset monitor.

---
 rtl/dma_att_pkg.sv | 36 +++
 rtl/dma_att_fifo.sv | 73 +++++++
 rtl/dma_att_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dma_att_pkg.sv
// Shared types, default region map and the region test for the attestation DMA scheduler.
package dma_att_pkg;

   typedef enum logic [1:0] {
      ST_LOCK  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [15:0] DEF_SROM_BASE     = 16'hA000;
   localparam logic [15:0] DEF_SROM_SIZE     = 16'h1000;
   localparam logic [15:0] DEF_SDATA_BASE    = 16'h0400;
   localparam logic [15:0] DEF_SDATA_SIZE    = 16'h0C00;
   localparam logic [15:0] DEF_CTR_BASE      = 16'h9000;
   localparam logic [15:0] DEF_CTR_SIZE      = 16'h0020;
   localparam logic [15:0] DEF_RESET_HANDLER = 16'h0000;
   localparam logic [15:0] DEF_HOLD_MAX      = 16'd1024;

   // A queue entry is {address, write enable}.
   localparam int FIFO_W = 17;

   // Half-open range check done in 17 bits so base+size never wraps.
   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
      logic [16:0] a17;
      logic [16:0] lo17;
      logic [16:0] hi17;
      a17  = {1'b0, addr};
      lo17 = {1'b0, base};
      hi17 = {1'b0, base} + {1'b0, size};
      return (a17 >= lo17) && (a17 < hi17);
   endfunction

endpackage

// File: rtl/dma_att_fifo.sv
// Two-entry request queue with flush; also reports the head and emptiness after this cycle's update.
module dma_att_fifo
   import dma_att_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [FIFO_W-1:0] i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [FIFO_W-1:0] o_head,
   output logic              o_nextEmpty,
   output logic [FIFO_W-1:0] o_nextHead
);

   logic [FIFO_W-1:0] r_mem [2];
   logic              r_rdPtr;
   logic              r_wrPtr;
   logic [1:0]        r_count;
   logic              w_doPush;
   logic              w_doPop;
   logic [1:0]        w_nextCount;
   logic [FIFO_W-1:0] w_nextHead;

   assign w_doPush = i_push && (r_count != 2'd2);
   assign w_doPop  = i_pop && (r_count != 2'd0);

   assign o_full      = (r_count == 2'd2);
   assign o_empty     = (r_count == 2'd0);
   assign o_head      = r_mem[r_rdPtr];
   assign o_nextEmpty = (w_nextCount == 2'd0);
   assign o_nextHead  = w_nextHead;

   // Look-ahead lets the scheduler load the following entry on the pop edge with no bubble.
   always_comb begin
      w_nextCount = r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
      w_nextHead  = r_mem[r_rdPtr];
      if (i_flush) begin
         w_nextCount = 2'd0;
         w_nextHead  = '0;
      end else if (r_count == 2'd0) begin
         w_nextHead = i_data;
      end else if (w_doPop) begin
         w_nextHead = (r_count == 2'd2) ? r_mem[~r_rdPtr] : i_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rdPtr  <= 1'b0;
         r_wrPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rdPtr <= 1'b0;
         r_wrPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= w_nextCount;
      end
   end

endmodule

// File: rtl/dma_att_scheduler.sv
// Queues DMA requests, holds them while attestation ROM runs and locks on secure-region access.
// Optional HOLD watchdog enabled by defining DMA_HOLD_TIMEOUT_EN.
module dma_att_scheduler
   import dma_att_pkg::*;
#(
   parameter logic [15:0] SROM_BASE     = DEF_SROM_BASE,
   parameter logic [15:0] SROM_SIZE     = DEF_SROM_SIZE,
   parameter logic [15:0] SDATA_BASE    = DEF_SDATA_BASE,
   parameter logic [15:0] SDATA_SIZE    = DEF_SDATA_SIZE,
   parameter logic [15:0] CTR_BASE      = DEF_CTR_BASE,
   parameter logic [15:0] CTR_SIZE      = DEF_CTR_SIZE,
   parameter logic [15:0] RESET_HANDLER = DEF_RESET_HANDLER,
   parameter logic [15:0] HOLD_MAX      = DEF_HOLD_MAX
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] pc,
   input  logic        dma_req_i,
   input  logic [15:0] dma_addr_i,
   input  logic        dma_we_i,
   output logic        dma_rdy_o,
   output logic        mem_dma_en_o,
   output logic [15:0] mem_dma_addr_o,
   output logic        mem_dma_we_o,
   input  logic        mem_dma_ready_i,
   output logic        hold_o,
   output logic        violation_o,
   output logic        timeout_o
);

   state_t            r_state;
   state_t            w_nextState;
   logic              w_inSrom;
   logic              w_illegal;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_full;
   logic              w_empty;
   logic              w_nextEmpty;
   logic [FIFO_W-1:0] w_head;
   logic [FIFO_W-1:0] w_nextHead;
   logic              r_en;
   logic [15:0]       r_addr;
   logic              r_we;
   logic              r_hold;
   logic              r_violation;

   assign w_inSrom  = in_region(pc, SROM_BASE, SROM_SIZE);
   assign w_illegal = dma_req_i && (r_state != ST_LOCK) &&
                      (in_region(dma_addr_i, SDATA_BASE, SDATA_SIZE) ||
                       in_region(dma_addr_i, CTR_BASE, CTR_SIZE));

   assign dma_rdy_o = !w_full && (r_state != ST_LOCK);
   assign w_push    = dma_req_i && dma_rdy_o && !w_illegal;
   assign w_pop     = (r_state == ST_ISSUE) && mem_dma_ready_i && !w_illegal;
   assign w_flush   = (r_state == ST_LOCK) || w_illegal;

   dma_att_fifo u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_flush     (w_flush),
      .i_data      ({dma_addr_i, dma_we_i}),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head),
      .o_nextEmpty (w_nextEmpty),
      .o_nextHead  (w_nextHead)
   );

   // A violation overrides everything, including an access that is just completing.
   always_comb begin
      w_nextState = r_state;
      if (w_illegal) begin
         w_nextState = ST_LOCK;
      end else begin
         unique case (r_state)
            ST_LOCK:  if (pc == RESET_HANDLER) w_nextState = ST_IDLE;
            ST_IDLE:  if (!w_empty) w_nextState = w_inSrom ? ST_HOLD : ST_ISSUE;
            ST_ISSUE: if (mem_dma_ready_i) begin
                         if (w_nextEmpty) w_nextState = ST_IDLE;
                         else             w_nextState = w_inSrom ? ST_HOLD : ST_ISSUE;
                      end
            ST_HOLD:  if (!w_inSrom) w_nextState = w_empty ? ST_IDLE : ST_ISSUE;
            default:  w_nextState = ST_LOCK;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_LOCK;
         r_en        <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_hold      <= 1'b0;
         r_violation <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_en        <= (w_nextState == ST_ISSUE);
         r_hold      <= (w_nextState == ST_HOLD);
         r_violation <= w_illegal;
         if (w_nextState == ST_ISSUE) begin
            {r_addr, r_we} <= w_pop ? w_nextHead : w_head;
         end
      end
   end

   assign mem_dma_en_o   = r_en;
   assign mem_dma_addr_o = r_addr;
   assign mem_dma_we_o   = r_we;
   assign hold_o         = r_hold;
   assign violation_o    = r_violation;

`ifdef DMA_HOLD_TIMEOUT_EN
   logic [15:0] r_holdCnt;
   logic [15:0] w_holdCntNext;
   logic        r_timeout;

   // Counts HOLD cycles including the current one; saturation keeps the pulse to a single cycle.
   always_comb begin
      w_holdCntNext = '0;
      if (w_nextState == ST_HOLD) begin
         w_holdCntNext = (r_holdCnt == 16'hFFFF) ? r_holdCnt : r_holdCnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_holdCnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_holdCnt <= w_holdCntNext;
         r_timeout <= (w_nextState == ST_HOLD) && (r_holdCnt != 16'hFFFF) &&
                      (w_holdCntNext == HOLD_MAX);
      end
   end

   assign timeout_o = r_timeout;
`else
   assign timeout_o = 1'b0;
`endif

endmodule
